start_sequencer: RTL and testbench
==================================

// Module: start_sequencer
// PURPOSE
//  Parametrised power-up/start sequencer clocked from Clk_100M. Qualifies ePLL_LOCK, then enables
//  N_STAGE downstream stages one by one, each after STAGE_TICKS ticks of the slow Clk_800K reference.
//  Asserts SYS_START once every stage is enabled. Drops all enables and flags a fault on lock loss,
//  holds off, then re-sequences. Replaces the single fixed-delay start pulse in the top-level start path.
// PARAMETERS
//  N_STAGE     4        number of stage enables (>=1)
//  CNT_W       16       tick counter width; every *_TICKS value must be < 2**CNT_W
//  LOCK_TICKS  8        consecutive ticks ePLL_LOCK must stay high before staging (>=1)
//  STAGE_TICKS 1000     ticks between successive stage enables (>=1)
//  HOLD_TICKS  400      ticks spent in FAULT before returning to IDLE (>=1)
//  BIAS_CODE   16'h7FFF constant driven on Bias_Control
// PORTS
//  Clk_100M     in   1        system clock; all logic on posedge
//  Rst_n        in   1        asynchronous active-low reset
//  Clk_800K     in   1        slow reference, asynchronous to Clk_100M; 2-flop synchronised
//  ePLL_LOCK    in   1        PLL lock, asynchronous; 2-flop synchronised
//  Restart      in   1        synchronous 1-cycle request: abort and return to IDLE
//  Stage_En     out  N_STAGE  thermometer stage enables, bit 0 first
//  SYS_START    out  1        high while in RUN
//  Lock_Fault   out  1        sticky: lock lost during STAGE or RUN
//  Seq_State    out  3        current state encoding (debug)
//  Bias_Control out  16       = BIAS_CODE, constant
// BEHAVIOUR
//  Reset (async, Rst_n=0): state IDLE, counters 0, Stage_En=0, SYS_START=0, Lock_Fault=0,
//   sync flops 0. Bias_Control = BIAS_CODE always, including during reset.
//  tick = 1-cycle pulse on the rising edge of synchronised Clk_800K (3rd flop for edge detect).
//   Latency is 3 Clk_100M cycles from the input edge. lock_s = ePLL_LOCK after 2 flops.
//  All outputs registered. States: IDLE=0, LOCKQ=1, STAGE=2, RUN=3, FAULT=4.
//  Priority each cycle: Restart > lock loss > tick.
//  IDLE:  cnt=0, idx=0. If lock_s=1 -> LOCKQ.
//  LOCKQ: if lock_s=0 -> IDLE with cnt=0; no fault.
//   On a tick: if cnt==LOCK_TICKS-1 -> STAGE with cnt=0, idx=0; else cnt++.
//  STAGE: on a tick: if cnt==STAGE_TICKS-1, set Stage_En[idx], clear cnt, idx++; else cnt++.
//   If idx==N_STAGE-1 when its bit is set, go to RUN. SYS_START rises in the same cycle as Stage_En[N_STAGE-1].
//  RUN:   Stage_En all 1, SYS_START=1. Ticks ignored.
//  Lock loss (lock_s=0) in STAGE or RUN -> FAULT. Next cycle: Stage_En=0, SYS_START=0, Lock_Fault=1, cnt=0.
//  FAULT: on a tick: if cnt==HOLD_TICKS-1 -> IDLE; else cnt++. Lock state is ignored during the hold.
//  Restart=1 in any state -> IDLE next cycle: Stage_En=0, SYS_START=0, cnt=idx=0, Lock_Fault=0.
//   Restart in the same cycle as lock loss: Restart wins, so Lock_Fault stays 0.
//  Lock_Fault clears only on Restart or reset; re-sequencing after FAULT does not clear it.
//  Stage_En[k] rises on tick number LOCK_TICKS+(k+1)*STAGE_TICKS, counting the first tick in LOCKQ as 1.
//  A stuck Clk_800K produces no ticks: the sequence stalls in its current state. This is not an error.
//  Counters never wrap: every compare is an equality against a parameter below 2**CNT_W.
// TESTING (bench: N_STAGE=3, LOCK_TICKS=2, STAGE_TICKS=4, HOLD_TICKS=3, Clk_800K period 125 clk)
//  1 Reset: hold Rst_n=0 with lock high and Clk_800K toggling -> Stage_En=0, SYS_START=0,
//    Lock_Fault=0, Seq_State=0, Bias_Control=16'h7FFF.
//  2 Nominal: release reset with lock high -> Stage_En bits rise at ticks 6, 10, 14.
//    SYS_START=1 in the same cycle as Stage_En=3'b111; Seq_State=3.
//  3 Lock glitch in LOCKQ: lock low for 10 clk after tick 1 -> Seq_State returns to 0, Lock_Fault=0.
//    The count restarts, and Stage_En[0] rises 6 ticks after lock returns.
//  4 Lock loss in RUN: drop lock -> within 3 clk Stage_En=0, SYS_START=0, Lock_Fault=1, Seq_State=4.
//    After 3 ticks -> IDLE, then full re-sequence with Lock_Fault still 1.
//  5 Restart in the same cycle that lock_s falls in STAGE -> IDLE, Lock_Fault=0. Also pulse
//    Restart in RUN with lock high -> SYS_START drops, re-sequence completes after 14 ticks.
//  6 Async reset mid-STAGE (Stage_En=3'b001): Rst_n low between clock edges -> outputs clear
//    immediately. After release, a full sequence runs from tick 1.

Source files
------------

// File: rtl/start_sequencer.sv
// Power-up start sequencer: qualifies PLL lock, enables stages one by one on slow
// reference ticks, raises SYS_START when all are on, and faults/holds off on lock loss.
module start_sequencer #(
  parameter int          N_STAGE     = 4,
  parameter int          CNT_W       = 16,
  parameter int          LOCK_TICKS  = 8,
  parameter int          STAGE_TICKS = 1000,
  parameter int          HOLD_TICKS  = 400,
  parameter logic [15:0] BIAS_CODE   = 16'h7FFF
) (
  input  logic               Clk_100M,
  input  logic               Rst_n,
  input  logic               Clk_800K,
  input  logic               ePLL_LOCK,
  input  logic               Restart,
  output logic [N_STAGE-1:0] Stage_En,
  output logic               SYS_START,
  output logic               Lock_Fault,
  output logic [2:0]         Seq_State,
  output logic [15:0]        Bias_Control
);

  localparam int IDX_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TICKS - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_STAGE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOCKQ = 3'd1,
    S_STAGE = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_STAGE-1:0] stage_en_q, stage_en_d;
  logic               sys_start_q, sys_start_d;
  logic               lock_fault_q, lock_fault_d;
  logic [2:0]         clk8_q;
  logic [1:0]         lock_sync_q;
  logic               tick;
  logic               lock_s;

  // Third reference flop exists only to detect the rising edge of the synchronised clock.
  assign tick   = clk8_q[1] & ~clk8_q[2];
  assign lock_s = lock_sync_q[1];

  always_ff @(posedge Clk_100M or negedge Rst_n) begin
    if (!Rst_n) begin
      clk8_q       <= '0;
      lock_sync_q  <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      stage_en_q   <= '0;
      sys_start_q  <= 1'b0;
      lock_fault_q <= 1'b0;
    end else begin
      clk8_q       <= {clk8_q[1:0], Clk_800K};
      lock_sync_q  <= {lock_sync_q[0], ePLL_LOCK};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stage_en_q   <= stage_en_d;
      sys_start_q  <= sys_start_d;
      lock_fault_q <= lock_fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    stage_en_d   = stage_en_q;
    sys_start_d  = sys_start_q;
    lock_fault_d = lock_fault_q;
    if (Restart) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      idx_d        = '0;
      stage_en_d   = '0;
      sys_start_d  = 1'b0;
      lock_fault_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          idx_d = '0;
          if (lock_s) state_d = S_LOCKQ;
        end
        S_LOCKQ: begin
          if (!lock_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == LOCK_LAST) begin
              state_d = S_STAGE;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        S_STAGE, S_RUN: begin
          if (!lock_s) begin
            state_d      = S_FAULT;
            cnt_d        = '0;
            idx_d        = '0;
            stage_en_d   = '0;
            sys_start_d  = 1'b0;
            lock_fault_d = 1'b1;
          end else if (state_q == S_STAGE && tick) begin
            if (cnt_q == STAGE_LAST) begin
              stage_en_d[idx_q] = 1'b1;
              cnt_d             = '0;
              // Last enable and SYS_START land on the same edge.
              if (idx_q == IDX_LAST) begin
                state_d     = S_RUN;
                sys_start_d = 1'b1;
              end else begin
                idx_d = idx_q + IDX_ONE;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        S_FAULT: begin
          if (tick) begin
            if (cnt_q == HOLD_LAST) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign Stage_En     = stage_en_q;
  assign SYS_START    = sys_start_q;
  assign Lock_Fault   = lock_fault_q;
  assign Seq_State    = state_q;
  assign Bias_Control = BIAS_CODE;

endmodule

// File: tb/tb_start_sequencer.sv
// Bench for start_sequencer: stimulus table, hand-written corner sequences and a
// random phase, all checked every cycle against a tick-counting reference model.
module tb_start_sequencer;

  localparam int          N    = 3;
  localparam int          LT   = 2;
  localparam int          ST   = 4;
  localparam int          HT   = 3;
  localparam int          SEQ_END = LT + N * ST;
  localparam logic [15:0] BIAS = 16'h7FFF;

  logic         clk = 1'b0;
  logic         Rst_n;
  logic         Clk_800K = 1'b0;
  logic         ePLL_LOCK;
  logic         Restart;
  logic [N-1:0] Stage_En;
  logic         SYS_START;
  logic         Lock_Fault;
  logic [2:0]   Seq_State;
  logic [15:0]  Bias_Control;

  int n_tests = 0;
  int n_fail  = 0;

  start_sequencer #(
    .N_STAGE(N), .CNT_W(16), .LOCK_TICKS(LT), .STAGE_TICKS(ST),
    .HOLD_TICKS(HT), .BIAS_CODE(BIAS)
  ) dut (
    .Clk_100M(clk), .Rst_n(Rst_n), .Clk_800K(Clk_800K), .ePLL_LOCK(ePLL_LOCK),
    .Restart(Restart), .Stage_En(Stage_En), .SYS_START(SYS_START),
    .Lock_Fault(Lock_Fault), .Seq_State(Seq_State), .Bias_Control(Bias_Control)
  );

  // clock / reference generation
  always #5 clk = ~clk;

  int half_cnt  = 0;
  int rise_cnt  = 0;
  bit clk8_run  = 1'b1;

  // 125-cycle reference: 63 cycles high, 62 low; freezes while clk8_run is 0.
  always @(negedge clk) begin
    if (clk8_run) begin
      if (half_cnt == (Clk_800K ? 62 : 61)) begin
        half_cnt <= 0;
        Clk_800K <= ~Clk_800K;
        if (!Clk_800K) rise_cnt <= rise_cnt + 1;
      end else begin
        half_cnt <= half_cnt + 1;
      end
    end
  end

  // reference model: one tick count per phase instead of counters/indices
  typedef struct {
    int mode;   // 0 idle, 1 active (qualify/stage/run), 2 fault hold
    int ticks;
    bit flt;
  } mdl_t;

  mdl_t m;
  bit   lp1, lp2, cp1, cp2, cp3;

  function automatic mdl_t mdl_step(mdl_t x, bit lk, bit tk, bit rs);
    mdl_t y;
    y = x;
    if (rs) begin
      y.mode = 0; y.ticks = 0; y.flt = 1'b0;
    end else begin
      case (x.mode)
        0: if (lk) begin y.mode = 1; y.ticks = 0; end
        1: begin
          if (!lk) begin
            if (x.ticks >= LT) begin y.mode = 2; y.flt = 1'b1; end
            else y.mode = 0;
            y.ticks = 0;
          end else if (tk && x.ticks < SEQ_END) begin
            y.ticks = x.ticks + 1;
          end
        end
        default: begin
          if (tk) begin
            y.ticks = x.ticks + 1;
            if (y.ticks == HT) begin y.mode = 0; y.ticks = 0; end
          end
        end
      endcase
    end
    return y;
  endfunction

  function automatic logic [23:0] mdl_vec(mdl_t x);
    logic [2:0] st;
    logic [2:0] en;
    logic       sys;
    int         k;
    en  = '0;
    sys = 1'b0;
    if (x.mode == 0) st = 3'd0;
    else if (x.mode == 2) st = 3'd4;
    else if (x.ticks < LT) st = 3'd1;
    else if (x.ticks < SEQ_END) st = 3'd2;
    else st = 3'd3;
    if (x.mode == 1 && x.ticks >= LT) begin
      k = (x.ticks - LT) / ST;
      if (k > N) k = N;
      en  = 3'((1 << k) - 1);
      sys = (x.ticks >= SEQ_END);
    end
    return {st, en, sys, x.flt, BIAS};
  endfunction

  always @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m   <= '{0, 0, 1'b0};
      lp1 <= 1'b0; lp2 <= 1'b0;
      cp1 <= 1'b0; cp2 <= 1'b0; cp3 <= 1'b0;
    end else begin
      lp1 <= ePLL_LOCK; lp2 <= lp1;
      cp1 <= Clk_800K;  cp2 <= cp1; cp3 <= cp2;
      m   <= mdl_step(m, lp2, cp2 & ~cp3, Restart);
    end
  end

  // scoreboard helpers
  function automatic logic [23:0] dut_vec();
    return {Seq_State, Stage_En, SYS_START, Lock_Fault, Bias_Control};
  endfunction

  task automatic cmp(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s @%0t: got st=%0d en=%b sys=%b flt=%b bias=%h, expected st=%0d en=%b sys=%b flt=%b bias=%h",
                 name, $time, got[23:21], got[20:18], got[17], got[16], got[15:0],
                 exp[23:21], exp[20:18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // one clock, then compare DUT against the model away from the active edge
  task automatic cyc();
    @(negedge clk);
    cmp("model", dut_vec(), mdl_vec(m));
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int start;
      bit seen;
      start = rise_cnt;
      seen  = 1'b0;
      for (int g = 0; g < 400 && !seen; g++) begin
        cyc();
        if (rise_cnt != start) seen = 1'b1;
      end
      if (!seen) begin
        n_tests++; n_fail++;
        $display("FAIL tick_timeout: got no Clk_800K rise in 400 cycles, required one");
      end else begin
        repeat (3) cyc();
      end
    end
  endtask

  task automatic pulse_restart();
    Restart = 1'b1;
    cyc();
    Restart = 1'b0;
  endtask

  // release reset while the reference is low so the first tick is well clear
  task automatic release_reset();
    int start;
    bit seen;
    start = rise_cnt;
    seen  = 1'b0;
    for (int g = 0; g < 400 && !seen; g++) begin
      cyc();
      if (rise_cnt != start) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL release_timeout: got no Clk_800K rise in 400 cycles, required one");
    end
    repeat (70) cyc();
    Rst_n = 1'b1;
  endtask

  function automatic logic [23:0] ev(logic [2:0] st, logic [2:0] en, logic sys, logic flt);
    return {st, en, sys, flt, BIAS};
  endfunction

  typedef struct {
    bit         lock;
    bit         rst;
    int         ticks;
    int         extra;
    logic [2:0] st;
    logic [2:0] en;
    bit         sys;
    bit         flt;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 0,  4, 3'd1, 3'b000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1,  0, 3'd1, 3'b000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1,  0, 3'd2, 3'b000, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3,  0, 3'd2, 3'b000, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1,  0, 3'd2, 3'b001, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 4,  0, 3'd2, 3'b011, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3,  0, 3'd2, 3'b011, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1,  0, 3'd3, 3'b111, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2,  0, 3'd3, 3'b111, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 0,  2, 3'd3, 3'b111, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 0,  1, 3'd4, 3'b000, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 2,  0, 3'd4, 3'b000, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1,  0, 3'd1, 3'b000, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 13, 0, 3'd2, 3'b011, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1,  0, 3'd3, 3'b111, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 0,  0, 3'd0, 3'b000, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 0,  1, 3'd1, 3'b000, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 13, 0, 3'd2, 3'b011, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1,  0, 3'd3, 3'b111, 1'b1, 1'b0};

    Rst_n     = 1'b0;
    ePLL_LOCK = 1'b1;
    Restart   = 1'b0;

    // reset held with lock high and the reference running
    repeat (200) cyc();
    cmp("reset", dut_vec(), ev(3'd0, 3'b000, 1'b0, 1'b0));
    release_reset();

    // nominal sequence, lock loss in RUN, re-sequence, restart in RUN
    for (int i = 0; i < 19; i++) begin
      ePLL_LOCK = tbl[i].lock;
      if (tbl[i].rst) pulse_restart();
      wait_ticks(tbl[i].ticks);
      repeat (tbl[i].extra) cyc();
      cmp($sformatf("row%0d", i), dut_vec(), ev(tbl[i].st, tbl[i].en, tbl[i].sys, tbl[i].flt));
    end

    // lock glitch while qualifying
    pulse_restart();
    cyc();
    wait_ticks(1);
    cmp("glitch_lockq", dut_vec(), ev(3'd1, 3'b000, 1'b0, 1'b0));
    ePLL_LOCK = 1'b0;
    repeat (10) cyc();
    cmp("glitch_idle", dut_vec(), ev(3'd0, 3'b000, 1'b0, 1'b0));
    ePLL_LOCK = 1'b1;
    wait_ticks(5);
    cmp("glitch_t5", dut_vec(), ev(3'd2, 3'b000, 1'b0, 1'b0));
    wait_ticks(1);
    cmp("glitch_t6", dut_vec(), ev(3'd2, 3'b001, 1'b0, 1'b0));

    // Restart lands on the same edge that first sees lock_s low
    ePLL_LOCK = 1'b0;
    cyc();
    cyc();
    Restart = 1'b1;
    cyc();
    Restart = 1'b0;
    cmp("restart_vs_loss", dut_vec(), ev(3'd0, 3'b000, 1'b0, 1'b0));
    repeat (3) cyc();
    cmp("restart_vs_loss_hold", dut_vec(), ev(3'd0, 3'b000, 1'b0, 1'b0));

    // async reset mid-STAGE, between clock edges
    ePLL_LOCK = 1'b1;
    repeat (3) cyc();
    wait_ticks(6);
    cmp("pre_async", dut_vec(), ev(3'd2, 3'b001, 1'b0, 1'b0));
    #2 Rst_n = 1'b0;
    #1 cmp("async_reset", dut_vec(), ev(3'd0, 3'b000, 1'b0, 1'b0));
    release_reset();
    repeat (4) cyc();
    cmp("post_async_lockq", dut_vec(), ev(3'd1, 3'b000, 1'b0, 1'b0));
    wait_ticks(13);
    cmp("post_async_t13", dut_vec(), ev(3'd2, 3'b011, 1'b0, 1'b0));
    wait_ticks(1);
    cmp("post_async_run", dut_vec(), ev(3'd3, 3'b111, 1'b1, 1'b0));

    // random lock drops, restarts and reference stalls, checked by the model
    for (int it = 0; it < 30; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        ePLL_LOCK = 1'b1;
        repeat ($urandom_range(20, 600)) cyc();
      end else if (sel <= 6) begin
        ePLL_LOCK = 1'b0;
        repeat ($urandom_range(1, 30)) cyc();
        ePLL_LOCK = 1'b1;
      end else if (sel == 7) begin
        pulse_restart();
      end else if (sel == 8) begin
        clk8_run = 1'b0;
        repeat ($urandom_range(50, 300)) cyc();
        clk8_run = 1'b1;
      end else begin
        ePLL_LOCK = 1'b0;
        repeat ($urandom_range(0, 4)) cyc();
        pulse_restart();
        repeat ($urandom_range(0, 4)) cyc();
        ePLL_LOCK = 1'b1;
      end
    end
    repeat (5) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
